// File: rtl/full_adder_1bit.sv
// Registered 1-bit full adder with a PIPE_STAGES-deep output pipeline (leaf of the ripple-carry adder).
// Optional generate/propagate outputs are built when FULL_ADDER_1BIT_PG_EN is defined.
module full_adder_1bit #(
    parameter int PIPE_STAGES = 1
) (
    input  logic cin,
    input  logic a,
    input  logic b,
    input  logic clk,
    output logic sum,
    output logic cout,
    input  logic rst
`ifdef FULL_ADDER_1BIT_PG_EN
    ,
    output logic gen,
    output logic prop
`endif
);

`ifdef FULL_ADDER_1BIT_PG_EN
    localparam int W = 4;
`else
    localparam int W = 2;
`endif

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("full_adder_1bit: PIPE_STAGES must be in 1..4");
    end

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Stage word layout: [0]=sum, [1]=carry, [2]=generate, [3]=propagate.
    logic [W-1:0] core_s;
    logic [W-1:0] stage_r [PIPE_STAGES] = '{default: '0};

    // Combinational full-adder core feeding stage 1.
    always_comb begin
        core_s    = '0;
        core_s[0] = a ^ b ^ cin;
        core_s[1] = maj3(a, b, cin);
`ifdef FULL_ADDER_1BIT_PG_EN
        core_s[2] = a & b;
        core_s[3] = a ^ b;
`endif
    end

    // Output shift register; reset wins over data sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= core_s;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign sum  = stage_r[PIPE_STAGES-1][0];
    assign cout = stage_r[PIPE_STAGES-1][1];
`ifdef FULL_ADDER_1BIT_PG_EN
    assign gen  = stage_r[PIPE_STAGES-1][2];
    assign prop = stage_r[PIPE_STAGES-1][3];
`endif

endmodule

// File: tb/tb_full_adder_1bit.sv
// Bench for full_adder_1bit: one-stage and three-stage instances share inputs and are checked
// against an arithmetic reference model of sampled inputs and reset history.
module tb_full_adder_1bit;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic sum1, cout1, sum3, cout3;
`ifdef FULL_ADDER_1BIT_PG_EN
    logic gen1, prop1, gen3, prop3;
`endif

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // rec[k] = {prop, gen, cout, sum} for inputs sampled at edge k; rec_rst[k] = rst at edge k
    logic [3:0] rec     [0:4095];
    logic       rec_rst [0:4095];

    logic [4:0] tt [8] = '{5'b000_00, 5'b100_10, 5'b110_01, 5'b111_11,
                           5'b011_01, 5'b001_10, 5'b010_10, 5'b101_01};

    full_adder_1bit #(.PIPE_STAGES(1)) dut1 (
        .cin(cin), .a(a), .b(b), .clk(clk), .sum(sum1), .cout(cout1), .rst(rst)
`ifdef FULL_ADDER_1BIT_PG_EN
        , .gen(gen1), .prop(prop1)
`endif
    );

    full_adder_1bit #(.PIPE_STAGES(3)) dut3 (
        .cin(cin), .a(a), .b(b), .clk(clk), .sum(sum3), .cout(cout3), .rst(rst)
`ifdef FULL_ADDER_1BIT_PG_EN
        , .gen(gen3), .prop(prop3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result visible after edge n for a p-stage pipeline: inputs of edge n-p+1, zero if any reset since.
    function automatic logic [3:0] expect_out(input int p);
        int first;
        first = n - p + 1;
        if (first < 1) return 4'b0000;
        for (int k = first; k <= n; k++) begin
            if (rec_rst[k]) return 4'b0000;
        end
        return rec[first];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e1;
        logic [3:0] e3;
        e1 = expect_out(1);
        e3 = expect_out(3);
        total++;
        assert ({cout1, sum1} === e1[1:0]) else begin
            bad++;
            $error("FAIL %s p1 cout/sum observed=%b expected=%b", tag, {cout1, sum1}, e1[1:0]);
        end
        total++;
        assert ({cout3, sum3} === e3[1:0]) else begin
            bad++;
            $error("FAIL %s p3 cout/sum observed=%b expected=%b", tag, {cout3, sum3}, e3[1:0]);
        end
`ifdef FULL_ADDER_1BIT_PG_EN
        total++;
        assert ({prop1, gen1} === e1[3:2]) else begin
            bad++;
            $error("FAIL %s p1 prop/gen observed=%b expected=%b", tag, {prop1, gen1}, e1[3:2]);
        end
        total++;
        assert ({prop3, gen3} === e3[3:2]) else begin
            bad++;
            $error("FAIL %s p3 prop/gen observed=%b expected=%b", tag, {prop3, gen3}, e3[3:2]);
        end
`endif
    endtask

    task automatic do_edge(input logic ia, input logic ib, input logic ic, input logic ir,
                           input string tag);
        logic [1:0] ab;
        logic [1:0] t;
        a   = ia;
        b   = ib;
        cin = ic;
        rst = ir;
        ab  = {1'b0, ia} + {1'b0, ib};
        t   = ab + {1'b0, ic};
        @(posedge clk);
        n++;
        rec[n]     = {(ab == 2'd1), (ab == 2'd2), t};
        rec_rst[n] = ir;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic ra, rb, rc, rr;
        a = 1'b0; b = 1'b0; cin = 1'b0; rst = 1'b0;
        #2;
        check_all("powerup");

        // Reset priority, then release
        do_edge(1'b1, 1'b1, 1'b1, 1'b1, "reset");
        chk("reset_sum", sum1, 1'b0);
        chk("reset_cout", cout1, 1'b0);
        do_edge(1'b1, 1'b1, 1'b1, 1'b0, "release");
        chk("release_sum", sum1, 1'b1);
        chk("release_cout", cout1, 1'b1);

        // Exhaustive truth table, one vector per edge
        for (int i = 0; i < 8; i++) begin
            do_edge(tt[i][4], tt[i][3], tt[i][2], 1'b0, "truth");
            chk("truth_sum", sum1, tt[i][1]);
            chk("truth_cout", cout1, tt[i][0]);
        end

        // Input change while clk is low has no effect until the next rising edge
        do_edge(1'b0, 1'b0, 1'b0, 1'b0, "samp_pre");
        @(negedge clk);
        a = 1'b1;
        #1;
        chk("samp_low_sum", sum1, 1'b0);
        check_all("samp_low");
        do_edge(1'b1, 1'b0, 1'b0, 1'b0, "samp_edge");
        chk("samp_edge_sum", sum1, 1'b1);

        // Three-stage latency: carry shows exactly two edges after sampling, for one cycle
        for (int i = 0; i < 3; i++) do_edge(1'b0, 1'b0, 1'b0, 1'b0, "flush");
        do_edge(1'b1, 1'b1, 1'b0, 1'b0, "lat_n0");
        chk("lat_n0_cout", cout3, 1'b0);
        do_edge(1'b0, 1'b0, 1'b0, 1'b0, "lat_n1");
        chk("lat_n1_cout", cout3, 1'b0);
        do_edge(1'b0, 1'b0, 1'b0, 1'b0, "lat_n2");
        chk("lat_n2_cout", cout3, 1'b1);
        do_edge(1'b0, 1'b0, 1'b0, 1'b0, "lat_n3");
        chk("lat_n3_cout", cout3, 1'b0);

        // Mid-pipeline reset discards in-flight 111
        for (int i = 0; i < 3; i++) do_edge(1'b0, 1'b0, 1'b0, 1'b0, "flush");
        do_edge(1'b1, 1'b1, 1'b1, 1'b0, "mid_launch");
        do_edge(1'b0, 1'b0, 1'b0, 1'b1, "mid_rst");
        for (int i = 0; i < 3; i++) begin
            do_edge(1'b0, 1'b0, 1'b0, 1'b0, "mid_after");
            chk("mid_after_sum", sum3, 1'b0);
            chk("mid_after_cout", cout3, 1'b0);
        end

`ifdef FULL_ADDER_1BIT_PG_EN
        do_edge(1'b1, 1'b1, 1'b0, 1'b0, "pg_gen");
        chk("pg_gen_gen", gen1, 1'b1);
        chk("pg_gen_prop", prop1, 1'b0);
        chk("pg_gen_cout", cout1, 1'b1);
        do_edge(1'b1, 1'b0, 1'b0, 1'b0, "pg_prop");
        chk("pg_prop_gen", gen1, 1'b0);
        chk("pg_prop_prop", prop1, 1'b1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 1) == 1);
            rb = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 15) == 0);
            do_edge(ra, rb, rc, rr, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
